// File: rtl/tcp_tx_sched.sv
// Purpose : arbitrates the TCP tx header path between control, fast-retransmit, keep-alive and data sources.
// Latency : 1 cycle from request to tx_val; gnt is combinational with tx_acc; src_done is combinational with tx_done.
// Backpr. : holds the latched header with tx_val until tx_acc; a timeout abort fires if tx_done never comes.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req / req_flags / req_seq / req_ack / req_len
//                         per-source request level and packed header fields ({fin,syn,rst,psh,ack})
//   flush                 connection teardown, aborts any packet in flight
//   gnt / src_done / err  one-hot accept pulse, one-hot completion pulse, timeout pulse
//   tx_val / tx_flags / tx_seq / tx_ack / tx_len / tx_acc / tx_done
//                         header handshake toward the tx header engine
//   busy                  a packet is being offered or transmitted
module tcp_tx_sched #(
    parameter int N_SRC   = 4,
    parameter int TMO_CYC = 1024,
    parameter int TMO_W   = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRC-1:0]     req,
    input  logic [N_SRC*5-1:0]   req_flags,
    input  logic [N_SRC*32-1:0]  req_seq,
    input  logic [N_SRC*32-1:0]  req_ack,
    input  logic [N_SRC*16-1:0]  req_len,
    input  logic                 flush,
    output logic [N_SRC-1:0]     gnt,
    output logic [N_SRC-1:0]     src_done,
    output logic                 err,
    output logic                 tx_val,
    output logic [4:0]           tx_flags,
    output logic [31:0]          tx_seq,
    output logic [31:0]          tx_ack,
    output logic [15:0]          tx_len,
    input  logic                 tx_acc,
    input  logic                 tx_done,
    output logic                 busy
);

    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
    localparam logic [IW-1:0]    IDX_ONE  = IW'(1);
    localparam logic [IW-1:0]    IDX_TOP  = IW'(N_SRC - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        OFFER     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0]  flags;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [15:0] len;
    } hdr_t;

    state_t            state;
    state_t            state_nxt;
    logic [IW-1:0]     win;
    logic [IW-1:0]     win_nxt;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     ptr_after;
    logic [IW-1:0]     rr_pick;
    logic              rr_found;
    logic [N_SRC-1:0]  win_oh;
    hdr_t              hdr;
    hdr_t              hdr_nxt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              any_req;
    logic              offer_acc;
    logic              arb_take;

    // k-th candidate of the round-robin ring 1..N_SRC-1, starting at p.
    // Source 0 is never part of the ring; it wins by fixed priority instead.
    function automatic logic [IW-1:0] rr_cand(input logic [IW-1:0] p, input int k);
        int base;
        base = ((int'(p) + k - 1) % (N_SRC - 1)) + 1;
        return IW'(base);
    endfunction

    assign any_req = |req;

    // Round-robin search over the low-priority sources.
    always_comb begin
        rr_pick  = IDX_ONE;
        rr_found = 1'b0;
        for (int k = 0; k < N_SRC - 1; k++) begin
            if (!rr_found && req[rr_cand(ptr, k)]) begin
                rr_pick  = rr_cand(ptr, k);
                rr_found = 1'b1;
            end
        end
    end

    assign win_nxt = req[0] ? '0 : rr_pick;

    always_comb begin
        hdr_nxt       = '0;
        hdr_nxt.flags = req_flags[int'(win_nxt)*5  +: 5];
        hdr_nxt.seq   = req_seq  [int'(win_nxt)*32 +: 32];
        hdr_nxt.ack   = req_ack  [int'(win_nxt)*32 +: 32];
        hdr_nxt.len   = req_len  [int'(win_nxt)*16 +: 16];
    end

    // Pointer moves one past the accepted source, wrapping back to 1.
    assign ptr_after = (win == IDX_TOP) ? IDX_ONE : (win + IDX_ONE);
    assign win_oh    = N_SRC'(1) << win;

    assign offer_acc = (state == OFFER) && tx_acc && !flush;
    assign arb_take  = (state == IDLE) && any_req && !flush;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs. flush and rst suppress every pulse
    // and drop tx_val in the same cycle they are seen.
    always_comb begin
        state_nxt = state;
        gnt       = '0;
        src_done  = '0;
        err       = 1'b0;
        tx_val    = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                tx_val = 1'b1;
                // Accept beats a same-cycle withdrawal.
                if (tx_acc) begin
                    gnt       = win_oh;
                    state_nxt = WAIT_DONE;
                end else if (!req[win]) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                // Completion beats a same-cycle timeout.
                if (tx_done) begin
                    src_done  = win_oh;
                    state_nxt = IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    err       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (flush || rst) begin
            state_nxt = IDLE;
            gnt       = '0;
            src_done  = '0;
            err       = 1'b0;
            tx_val    = 1'b0;
        end
    end

    // Winner, header latch, round-robin pointer and timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            win     <= '0;
            ptr     <= IDX_ONE;
            hdr     <= '0;
            tmo_cnt <= '0;
        end else begin
            // Header only changes on IDLE->OFFER so the engine sees stable fields.
            if (arb_take) begin
                win <= win_nxt;
                hdr <= hdr_nxt;
            end

            if (flush) begin
                ptr <= IDX_ONE;
            end else if (offer_acc && (win != '0)) begin
                ptr <= ptr_after;
            end

            if (offer_acc) begin
                tmo_cnt <= '0;
            end else if (state == WAIT_DONE) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    assign tx_flags = hdr.flags;
    assign tx_seq   = hdr.seq;
    assign tx_ack   = hdr.ack;
    assign tx_len   = hdr.len;
    assign busy     = (state != IDLE);

endmodule
